// File: rtl/equ_1_2.sv
// 5x5 patch row sums plus vertical absolute-difference gradient, two-stage pipeline with stall.
// Optional in_valid/out_valid tracking is enabled by defining EQU_1_2_VALID_EN.
module equ_1_2 #(
    parameter int PIXEL_W = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
`ifdef EQU_1_2_VALID_EN
    input  logic                 in_valid,
    output logic                 out_valid,
`endif
    input  logic [PIXEL_W-1:0]   p_0_0, p_0_1, p_0_2, p_0_3, p_0_4,
    input  logic [PIXEL_W-1:0]   p_1_0, p_1_1, p_1_2, p_1_3, p_1_4,
    input  logic [PIXEL_W-1:0]   p_2_0, p_2_1, p_2_2, p_2_3, p_2_4,
    input  logic [PIXEL_W-1:0]   p_3_0, p_3_1, p_3_2, p_3_3, p_3_4,
    input  logic [PIXEL_W-1:0]   p_4_0, p_4_1, p_4_2, p_4_3, p_4_4,
    output logic [PIXEL_W+2:0]   r1_sum,
    output logic [PIXEL_W+2:0]   r2_sum,
    output logic [PIXEL_W+2:0]   r3_sum,
    output logic [PIXEL_W+2:0]   r4_sum,
    output logic [PIXEL_W+2:0]   r5_sum,
    output logic [PIXEL_W+4:0]   grad
);

    localparam int SUM_W  = PIXEL_W + 3;
    localparam int GRAD_W = PIXEL_W + 5;

    logic [PIXEL_W-1:0] w_pix      [5][5];
    logic [PIXEL_W-1:0] w_diff     [20];
    logic [SUM_W-1:0]   w_row_sum  [5];
    logic [GRAD_W-1:0]  w_grad_sum;
    logic               w_adv;

    logic [PIXEL_W-1:0] r_diff     [20];
    logic [SUM_W-1:0]   r_sum_s1   [5];
    logic [SUM_W-1:0]   r_sum_s2   [5];
    logic [GRAD_W-1:0]  r_grad;

    assign w_adv = ~stall;

    assign w_pix[0][0] = p_0_0; assign w_pix[0][1] = p_0_1; assign w_pix[0][2] = p_0_2;
    assign w_pix[0][3] = p_0_3; assign w_pix[0][4] = p_0_4;
    assign w_pix[1][0] = p_1_0; assign w_pix[1][1] = p_1_1; assign w_pix[1][2] = p_1_2;
    assign w_pix[1][3] = p_1_3; assign w_pix[1][4] = p_1_4;
    assign w_pix[2][0] = p_2_0; assign w_pix[2][1] = p_2_1; assign w_pix[2][2] = p_2_2;
    assign w_pix[2][3] = p_2_3; assign w_pix[2][4] = p_2_4;
    assign w_pix[3][0] = p_3_0; assign w_pix[3][1] = p_3_1; assign w_pix[3][2] = p_3_2;
    assign w_pix[3][3] = p_3_3; assign w_pix[3][4] = p_3_4;
    assign w_pix[4][0] = p_4_0; assign w_pix[4][1] = p_4_1; assign w_pix[4][2] = p_4_2;
    assign w_pix[4][3] = p_4_3; assign w_pix[4][4] = p_4_4;

    // Larger minus smaller keeps each difference unsigned at PIXEL_W bits.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        for (int i = 0; i < 20; i++) w_diff[i] = '0;
        for (int r = 0; r < 5; r++) w_row_sum[r] = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) begin
                w_diff[r*5+c] = (w_pix[r][c] >= w_pix[r+1][c]) ? (w_pix[r][c] - w_pix[r+1][c])
                                                                : (w_pix[r+1][c] - w_pix[r][c]);
            end
        end
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                w_row_sum[r] = w_row_sum[r] + SUM_W'(w_pix[r][c]);
            end
        end
    end

    always_comb begin
        w_grad_sum = '0;
        for (int i = 0; i < 20; i++) w_grad_sum = w_grad_sum + GRAD_W'(r_diff[i]);
    end

    // NOTE: state uses non-blocking assignments so both stages sample pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 20; i++) r_diff[i] <= '0;
            for (int r = 0; r < 5; r++) begin
                r_sum_s1[r] <= '0;
                r_sum_s2[r] <= '0;
            end
            r_grad <= '0;
        end else if (w_adv) begin
            for (int i = 0; i < 20; i++) r_diff[i] <= w_diff[i];
            for (int r = 0; r < 5; r++) begin
                r_sum_s1[r] <= w_row_sum[r];
                r_sum_s2[r] <= r_sum_s1[r];
            end
            r_grad <= w_grad_sum;
        end
    end

`ifdef EQU_1_2_VALID_EN
    logic r_vld_s1;
    logic r_vld_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_s1 <= 1'b0;
            r_vld_s2 <= 1'b0;
        end else if (w_adv) begin
            r_vld_s1 <= in_valid;
            r_vld_s2 <= r_vld_s1;
        end
    end

    assign out_valid = r_vld_s2;
`endif

    assign r1_sum = r_sum_s2[0];
    assign r2_sum = r_sum_s2[1];
    assign r3_sum = r_sum_s2[2];
    assign r4_sum = r_sum_s2[3];
    assign r5_sum = r_sum_s2[4];
    assign grad   = r_grad;

endmodule

// File: tb/tb_equ_1_2.sv
// Directed self-checking bench for equ_1_2: latency, stall hold, async reset, width extremes.
// Define EQU_1_2_VALID_EN to also check the in_valid/out_valid pipe.
module tb_equ_1_2;

    localparam int PIXEL_W = 12;

    logic                clk;
    logic                rst;
    logic                stall;
    logic                in_valid;
    logic                out_valid;
    logic [PIXEL_W-1:0]  pix [5][5];
    logic [PIXEL_W+2:0]  r1_sum, r2_sum, r3_sum, r4_sum, r5_sum;
    logic [PIXEL_W+4:0]  grad;

    int total = 0;
    int bad   = 0;

    equ_1_2 #(.PIXEL_W(PIXEL_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
`ifdef EQU_1_2_VALID_EN
        .in_valid (in_valid),
        .out_valid(out_valid),
`endif
        .p_0_0(pix[0][0]), .p_0_1(pix[0][1]), .p_0_2(pix[0][2]), .p_0_3(pix[0][3]), .p_0_4(pix[0][4]),
        .p_1_0(pix[1][0]), .p_1_1(pix[1][1]), .p_1_2(pix[1][2]), .p_1_3(pix[1][3]), .p_1_4(pix[1][4]),
        .p_2_0(pix[2][0]), .p_2_1(pix[2][1]), .p_2_2(pix[2][2]), .p_2_3(pix[2][3]), .p_2_4(pix[2][4]),
        .p_3_0(pix[3][0]), .p_3_1(pix[3][1]), .p_3_2(pix[3][2]), .p_3_3(pix[3][3]), .p_3_4(pix[3][4]),
        .p_4_0(pix[4][0]), .p_4_1(pix[4][1]), .p_4_2(pix[4][2]), .p_4_3(pix[4][3]), .p_4_4(pix[4][4]),
        .r1_sum(r1_sum), .r2_sum(r2_sum), .r3_sum(r3_sum), .r4_sum(r4_sum), .r5_sum(r5_sum),
        .grad  (grad)
    );

`ifndef EQU_1_2_VALID_EN
    assign out_valid = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int s1, input int s2, input int s3,
                             input int s4, input int s5, input int g);
        check({tag, ".r1"},   32'(r1_sum), 32'(s1));
        check({tag, ".r2"},   32'(r2_sum), 32'(s2));
        check({tag, ".r3"},   32'(r3_sum), 32'(s3));
        check({tag, ".r4"},   32'(r4_sum), 32'(s4));
        check({tag, ".r5"},   32'(r5_sum), 32'(s5));
        check({tag, ".grad"}, 32'(grad),   32'(g));
    endtask

    task automatic check_valid(input string tag, input logic exp);
`ifdef EQU_1_2_VALID_EN
        check({tag, ".out_valid"}, 32'(out_valid), 32'(exp));
`endif
    endtask

    // Every pixel of row r gets value rv[r].
    task automatic set_rows(input int a0, input int a1, input int a2, input int a3, input int a4);
        int rv[5];
        rv = '{a0, a1, a2, a3, a4};
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                pix[r][c] = PIXEL_W'(rv[r]);
    endtask

    task automatic set_checker();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                pix[r][c] = ((r + c) % 2 == 0) ? 12'd4095 : 12'd0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b0;
        stall    = 1'b0;
        in_valid = 1'b1;
        set_rows(7, 9, 11, 13, 15);
        step();
        step();
        check_out("reset", 0, 0, 0, 0, 0, 0);
        check_valid("reset", 1'b0);

        // Flat patch: 5*12 per row, no vertical change.
        rst = 1'b1;
        set_rows(12, 12, 12, 12, 12);
        step();
        check_out("flat.lat1", 0, 0, 0, 0, 0, 0);
        step();
        check_out("flat", 60, 60, 60, 60, 60, 0);
        check_valid("flat", 1'b1);

        // Row ramp: each vertical step is 100, 20 pairs -> 2000.
        set_rows(100, 200, 300, 400, 500);
        step();
        step();
        check_out("ramp", 500, 1000, 1500, 2000, 2500, 2000);

        // Full-scale checkerboard: grad 20*4095 = 81900.
        set_checker();
        step();
        step();
        check_out("checker", 12285, 8190, 12285, 8190, 12285, 81900);

        // Direction independence and equal pairs: |10-3|+|3-7|+0+|7-0| = 18 per column.
        set_rows(10, 3, 7, 7, 0);
        step();
        step();
        check_out("mixed", 50, 15, 35, 35, 0, 90);
        set_rows(0, 7, 7, 3, 10);
        step();
        step();
        check_out("mixed.rev", 0, 35, 35, 15, 50, 90);

        // Back-to-back patches on consecutive cycles.
        set_rows(12, 12, 12, 12, 12);
        in_valid = 1'b1;
        step();
        set_rows(100, 200, 300, 400, 500);
        in_valid = 1'b0;
        step();
        check_out("stream.A", 60, 60, 60, 60, 60, 0);
        check_valid("stream.A", 1'b1);
        step();
        check_out("stream.B", 500, 1000, 1500, 2000, 2500, 2000);
        check_valid("stream.B", 1'b0);

        // Stall mid-stream: outputs hold, inputs presented while stalled are ignored.
        set_rows(12, 12, 12, 12, 12);
        in_valid = 1'b1;
        step();
        set_rows(100, 200, 300, 400, 500);
        in_valid = 1'b0;
        step();
        check_out("stall.A", 60, 60, 60, 60, 60, 0);
        stall = 1'b1;
        set_checker();
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_out($sformatf("stall.hold%0d", k), 60, 60, 60, 60, 60, 0);
            check_valid($sformatf("stall.hold%0d", k), 1'b1);
        end
        stall = 1'b0;
        step();
        check_out("stall.B", 500, 1000, 1500, 2000, 2500, 2000);
        check_valid("stall.B", 1'b0);
        step();
        check_out("stall.C", 12285, 8190, 12285, 8190, 12285, 81900);
        check_valid("stall.C", 1'b1);

        // Asynchronous reset with patch B in flight clears outputs immediately.
        set_rows(12, 12, 12, 12, 12);
        step();
        set_rows(100, 200, 300, 400, 500);
        step();
        check_out("inflight.A", 60, 60, 60, 60, 60, 0);
        #1 rst = 1'b0;
        #1;
        check_out("async_rst", 0, 0, 0, 0, 0, 0);
        check_valid("async_rst", 1'b0);
        step();
        rst = 1'b1;
        set_rows(10, 3, 7, 7, 0);
        step();
        check_out("post_rst.lat1", 0, 0, 0, 0, 0, 0);
        check_valid("post_rst.lat1", 1'b0);
        step();
        check_out("post_rst", 50, 15, 35, 35, 0, 90);
        check_valid("post_rst", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so a stuck run still ends with a summary.
    initial begin
        #100000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
